// File: rtl/dispatch_stage.sv
// Dispatch stage: 2-entry in-order buffer between rename and the ALU/branch/LSU
// reservation stations, with a busy table for operand readiness. DISPATCH_BYPASS_EN
// forwards same-cycle writeback into the ready bits.
module dispatch_stage #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // rename side
    input  logic                  rn_valid,
    input  logic [PREG_WIDTH-1:0] rn_prs1,
    input  logic [PREG_WIDTH-1:0] rn_prs2,
    input  logic [PREG_WIDTH-1:0] rn_prd,
    input  logic [PREG_WIDTH-1:0] rn_old_prd,
    input  logic [ROB_WIDTH-1:0]  rn_rob_tag,
    input  logic                  rn_uses_rs1,
    input  logic                  rn_uses_rs2,
    input  logic                  rn_reg_write,
    input  logic [1:0]            rn_fu_type,
    output logic                  dispatch_ready,
    // reservation stations
    output logic [2:0]            rs_valid,
    input  logic [2:0]            rs_ready,
    output logic [PREG_WIDTH-1:0] rs_prs1,
    output logic [PREG_WIDTH-1:0] rs_prs2,
    output logic [PREG_WIDTH-1:0] rs_prd,
    output logic                  rs_prs1_rdy,
    output logic                  rs_prs2_rdy,
    output logic [ROB_WIDTH-1:0]  rs_rob_tag,
    // reorder buffer
    output logic                  rob_valid,
    input  logic                  rob_ready,
    output logic [PREG_WIDTH-1:0] rob_prd,
    output logic [PREG_WIDTH-1:0] rob_old_prd,
    output logic                  rob_reg_write,
    // writeback / flush
    input  logic                  wb_valid,
    input  logic [PREG_WIDTH-1:0] wb_preg,
    input  logic                  branch_mispredict,
    // performance counters
    output logic [31:0]           perf_dispatched,
    output logic [31:0]           perf_stall_rs,
    output logic [31:0]           perf_stall_rob
);

    localparam int NPREG = 2 ** PREG_WIDTH;

    typedef struct packed {
        logic [PREG_WIDTH-1:0] prs1;
        logic [PREG_WIDTH-1:0] prs2;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] old_prd;
        logic [ROB_WIDTH-1:0]  rob_tag;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic                  reg_write;
        logic [1:0]            fu;
    } dq_entry_t;

    dq_entry_t        q [2];
    dq_entry_t        hd;
    dq_entry_t        in_ent;
    logic             head_ptr, tail_ptr;
    logic [1:0]       count;
    logic [NPREG-1:0] busy, busy_nxt;
    logic             enq, fire, has_head;
    logic             byp1, byp2;

    assign has_head       = (count != 2'd0);
    assign dispatch_ready = (count != 2'd2) && !branch_mispredict;
    assign enq            = rn_valid && dispatch_ready;
    assign hd             = q[head_ptr];
    assign fire           = has_head && rs_ready[hd.fu] && rob_ready && !branch_mispredict;

    // Illegal fu_type 3 is folded to ALU at entry so the head never indexes past rs_ready.
    always_comb begin
        in_ent          = '0;
        in_ent.prs1     = rn_prs1;
        in_ent.prs2     = rn_prs2;
        in_ent.prd      = rn_prd;
        in_ent.old_prd  = rn_old_prd;
        in_ent.rob_tag  = rn_rob_tag;
        in_ent.uses_rs1 = rn_uses_rs1;
        in_ent.uses_rs2 = rn_uses_rs2;
        in_ent.reg_write = rn_reg_write;
        in_ent.fu       = (rn_fu_type == 2'd3) ? 2'd0 : rn_fu_type;
    end

`ifdef DISPATCH_BYPASS_EN
    assign byp1 = wb_valid && (wb_preg == hd.prs1);
    assign byp2 = wb_valid && (wb_preg == hd.prs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs_prs1_rdy = !hd.uses_rs1 || (hd.prs1 == '0) || !busy[hd.prs1] || byp1;
    assign rs_prs2_rdy = !hd.uses_rs2 || (hd.prs2 == '0) || !busy[hd.prs2] || byp2;

    assign rs_valid      = fire ? (3'b001 << hd.fu) : 3'b000;
    assign rob_valid     = fire;
    assign rs_prs1       = hd.prs1;
    assign rs_prs2       = hd.prs2;
    assign rs_prd        = hd.prd;
    assign rs_rob_tag    = hd.rob_tag;
    assign rob_prd       = hd.prd;
    assign rob_old_prd   = hd.old_prd;
    assign rob_reg_write = hd.reg_write;

    // Set after clear so a same-cycle allocate of a just-written preg stays busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_preg] = 1'b0;
        if (enq && rn_reg_write && (rn_prd != '0))
            busy_nxt[rn_prd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Payload storage carries no reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (enq)
            q[tail_ptr] <= in_ent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 2'd0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else if (branch_mispredict) begin
            count    <= 2'd0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            if (enq)
                tail_ptr <= ~tail_ptr;
            if (fire)
                head_ptr <= ~head_ptr;
            if (enq && !fire)
                count <= count + 2'd1;
            else if (fire && !enq)
                count <= count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_dispatched <= '0;
            perf_stall_rs   <= '0;
            perf_stall_rob  <= '0;
        end else begin
            if (fire)
                perf_dispatched <= perf_dispatched + 32'd1;
            if (has_head && rob_ready && !rs_ready[hd.fu])
                perf_stall_rs <= perf_stall_rs + 32'd1;
            if (has_head && !rob_ready)
                perf_stall_rob <= perf_stall_rob + 32'd1;
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: expected packets are queued on enqueue and
// popped when the head fires; ready-bit expectations follow DISPATCH_BYPASS_EN.
module tb_dispatch_stage;

    localparam int PW = 7;
    localparam int RW = 4;

`ifdef DISPATCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rn_valid;
    logic [PW-1:0] rn_prs1, rn_prs2, rn_prd, rn_old_prd;
    logic [RW-1:0] rn_rob_tag;
    logic          rn_uses_rs1, rn_uses_rs2, rn_reg_write;
    logic [1:0]    rn_fu_type;
    logic          dispatch_ready;
    logic [2:0]    rs_valid, rs_ready;
    logic [PW-1:0] rs_prs1, rs_prs2, rs_prd;
    logic          rs_prs1_rdy, rs_prs2_rdy;
    logic [RW-1:0] rs_rob_tag;
    logic          rob_valid, rob_ready;
    logic [PW-1:0] rob_prd, rob_old_prd;
    logic          rob_reg_write;
    logic          wb_valid;
    logic [PW-1:0] wb_preg;
    logic          branch_mispredict;
    logic [31:0]   perf_dispatched, perf_stall_rs, perf_stall_rob;

    always #5 clk = ~clk;

    dispatch_stage #(.PREG_WIDTH(PW), .ROB_WIDTH(RW)) dut (
        .clk(clk), .reset(reset),
        .rn_valid(rn_valid), .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_prd(rn_prd),
        .rn_old_prd(rn_old_prd), .rn_rob_tag(rn_rob_tag), .rn_uses_rs1(rn_uses_rs1),
        .rn_uses_rs2(rn_uses_rs2), .rn_reg_write(rn_reg_write), .rn_fu_type(rn_fu_type),
        .dispatch_ready(dispatch_ready),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_prs1(rs_prs1), .rs_prs2(rs_prs2),
        .rs_prd(rs_prd), .rs_prs1_rdy(rs_prs1_rdy), .rs_prs2_rdy(rs_prs2_rdy),
        .rs_rob_tag(rs_rob_tag),
        .rob_valid(rob_valid), .rob_ready(rob_ready), .rob_prd(rob_prd),
        .rob_old_prd(rob_old_prd), .rob_reg_write(rob_reg_write),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .branch_mispredict(branch_mispredict),
        .perf_dispatched(perf_dispatched), .perf_stall_rs(perf_stall_rs),
        .perf_stall_rob(perf_stall_rob)
    );

    typedef struct {
        logic [2:0]    oh;
        logic [PW-1:0] prs1, prs2, prd, old_prd;
        logic [RW-1:0] tag;
        logic          rw;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rn_valid = 1'b0;
    endtask

    task automatic drv(input logic [1:0] fu, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                       input logic [PW-1:0] pd, input logic [PW-1:0] po, input logic [RW-1:0] tg,
                       input logic u1, input logic u2, input logic w);
        rn_valid     = 1'b1;
        rn_fu_type   = fu;
        rn_prs1      = p1;
        rn_prs2      = p2;
        rn_prd       = pd;
        rn_old_prd   = po;
        rn_rob_tag   = tg;
        rn_uses_rs1  = u1;
        rn_uses_rs2  = u2;
        rn_reg_write = w;
    endtask

    task automatic push();
        exp_t e;
        case (rn_fu_type)
            2'd1:    e.oh = 3'b010;
            2'd2:    e.oh = 3'b100;
            default: e.oh = 3'b001;
        endcase
        e.prs1    = rn_prs1;
        e.prs2    = rn_prs2;
        e.prd     = rn_prd;
        e.old_prd = rn_old_prd;
        e.tag     = rn_rob_tag;
        e.rw      = rn_reg_write;
        sbq.push_back(e);
    endtask

    task automatic chk_fire(input string tag, input logic f, input logic r1, input logic r2);
        exp_t e;
        if (!f) begin
            chk({tag, ".rs_valid"}, 32'(rs_valid), 32'd0);
            chk({tag, ".rob_valid"}, 32'(rob_valid), 32'd0);
        end else if (sbq.size() == 0) begin
            chk({tag, ".sb_nonempty"}, 32'd0, 32'(rs_valid));
        end else begin
            e = sbq.pop_front();
            chk({tag, ".rs_valid"}, 32'(rs_valid), 32'(e.oh));
            chk({tag, ".rob_valid"}, 32'(rob_valid), 32'd1);
            chk({tag, ".prs1"}, 32'(rs_prs1), 32'(e.prs1));
            chk({tag, ".prs2"}, 32'(rs_prs2), 32'(e.prs2));
            chk({tag, ".rs_prd"}, 32'(rs_prd), 32'(e.prd));
            chk({tag, ".tag"}, 32'(rs_rob_tag), 32'(e.tag));
            chk({tag, ".rob_prd"}, 32'(rob_prd), 32'(e.prd));
            chk({tag, ".old_prd"}, 32'(rob_old_prd), 32'(e.old_prd));
            chk({tag, ".reg_write"}, 32'(rob_reg_write), 32'(e.rw));
            chk({tag, ".prs1_rdy"}, 32'(rs_prs1_rdy), 32'(r1));
            chk({tag, ".prs2_rdy"}, 32'(rs_prs2_rdy), 32'(r2));
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        drv(2'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        rn_valid = 1'b0;
        rs_ready = 3'b111;
        rob_ready = 1'b1;
        wb_valid = 1'b0;
        wb_preg = '0;
        branch_mispredict = 1'b0;

        #12;
        chk("rst.dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk_fire("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.perf_dispatched", perf_dispatched, 32'd0);
        chk("rst.perf_stall_rs", perf_stall_rs, 32'd0);
        chk("rst.perf_stall_rob", perf_stall_rob, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ALU op1: p5 <- p3
        drv(2'd0, 7'd3, 7'd0, 7'd5, 7'd20, 4'd1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("op1.enq_ready", 32'(dispatch_ready), 32'd1);
        chk_fire("empty", 1'b0, 1'b0, 1'b0);
        push();
        tick();

        // op2 reads p5 while op1 fires
        drv(2'd0, 7'd5, 7'd0, 7'd6, 7'd21, 4'd2, 1'b1, 1'b0, 1'b1);
        #1;
        chk_fire("op1", 1'b1, 1'b1, 1'b1);
        push();
        tick();

        // op2 fires with writeback of p5 in the same cycle
        idle();
        wb_valid = 1'b1;
        wb_preg  = 7'd5;
        #1;
        chk_fire("op2_wb", 1'b1, BYP, 1'b1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("op2.perf_dispatched", perf_dispatched, 32'd2);
        chk_fire("idle1", 1'b0, 1'b0, 1'b0);

        // LSU op3 blocked by rs_ready[2]=0, op4 queued behind it
        rs_ready = 3'b011;
        drv(2'd2, 7'd6, 7'd0, 7'd7, 7'd22, 4'd3, 1'b1, 1'b0, 1'b1);
        #1;
        push();
        tick();
        drv(2'd0, 7'd0, 7'd7, 7'd0, 7'd23, 4'd4, 1'b0, 1'b1, 1'b1);
        #1;
        chk("lsu.ready_cnt1", 32'(dispatch_ready), 32'd1);
        chk_fire("lsu_blk1", 1'b0, 1'b0, 1'b0);
        push();
        tick();
        drv(2'd1, 7'd1, 7'd1, 7'd30, 7'd30, 4'd15, 1'b1, 1'b1, 1'b1);
        #1;
        chk("lsu.ready_full", 32'(dispatch_ready), 32'd0);
        chk_fire("lsu_blk2", 1'b0, 1'b0, 1'b0);
        chk("lsu.stall_rs1", perf_stall_rs, 32'd1);
        tick();
        idle();
        #1;
        chk("lsu.stall_rs2", perf_stall_rs, 32'd2);
        chk("lsu.ready_full2", 32'(dispatch_ready), 32'd0);
        rs_ready = 3'b111;
        #1;
        chk_fire("op3", 1'b1, 1'b0, 1'b1);
        tick();
        chk_fire("op4", 1'b1, 1'b1, 1'b0);
        tick();
        chk_fire("idle2", 1'b0, 1'b0, 1'b0);
        chk("lsu.stall_rs_hold", perf_stall_rs, 32'd2);

        // ROB backpressure
        rob_ready = 1'b0;
        drv(2'd0, 7'd0, 7'd0, 7'd8, 7'd24, 4'd5, 1'b1, 1'b0, 1'b0);
        #1;
        push();
        tick();
        idle();
        #1;
        chk_fire("rob_blk1", 1'b0, 1'b0, 1'b0);
        chk("rob.stall0", perf_stall_rob, 32'd0);
        tick();
        chk_fire("rob_blk2", 1'b0, 1'b0, 1'b0);
        chk("rob.stall1", perf_stall_rob, 32'd1);
        tick();
        chk("rob.stall2", perf_stall_rob, 32'd2);
        chk("rob.stall_rs_hold", perf_stall_rs, 32'd2);
        rob_ready = 1'b1;
        #1;
        chk_fire("op5", 1'b1, 1'b1, 1'b1);
        tick();
        chk("rob.perf_dispatched", perf_dispatched, 32'd5);

        // Fill to 2 then flush
        rs_ready = 3'b000;
        drv(2'd0, 7'd0, 7'd0, 7'd9, 7'd25, 4'd6, 1'b0, 1'b0, 1'b1);
        #1;
        push();
        tick();
        drv(2'd1, 7'd9, 7'd0, 7'd10, 7'd26, 4'd7, 1'b1, 1'b0, 1'b1);
        #1;
        push();
        tick();
        idle();
        rs_ready = 3'b111;
        branch_mispredict = 1'b1;
        #1;
        chk("flush.ready", 32'(dispatch_ready), 32'd0);
        chk_fire("flush", 1'b0, 1'b0, 1'b0);
        tick();
        sbq.delete();
        branch_mispredict = 1'b0;
        drv(2'd0, 7'd9, 7'd10, 7'd0, 7'd27, 4'd8, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush.ready_after", 32'(dispatch_ready), 32'd1);
        chk_fire("flush_empty", 1'b0, 1'b0, 1'b0);
        push();
        tick();

        // op8 sees busy bits from squashed ops; op9 (fu=3) sets p11 while wb clears it
        drv(2'd3, 7'd0, 7'd0, 7'd11, 7'd28, 4'd9, 1'b0, 1'b0, 1'b1);
        wb_valid = 1'b1;
        wb_preg  = 7'd11;
        #1;
        chk_fire("op8", 1'b1, 1'b0, 1'b0);
        push();
        tick();
        wb_valid = 1'b0;
        drv(2'd0, 7'd11, 7'd0, 7'd0, 7'd29, 4'd10, 1'b1, 1'b0, 1'b0);
        #1;
        chk_fire("op9_fu3", 1'b1, 1'b1, 1'b1);
        push();
        tick();
        idle();
        #1;
        chk_fire("op10_setwins", 1'b1, 1'b0, 1'b1);
        tick();

        // Reset while stalled full
        rs_ready = 3'b000;
        drv(2'd0, 7'd1, 7'd2, 7'd12, 7'd31, 4'd11, 1'b1, 1'b1, 1'b1);
        #1;
        push();
        tick();
        drv(2'd2, 7'd3, 7'd4, 7'd13, 7'd32, 4'd12, 1'b1, 1'b1, 1'b1);
        #1;
        push();
        tick();
        idle();
        #1;
        chk("mrst.full", 32'(dispatch_ready), 32'd0);
        rs_ready = 3'b111;
        reset = 1'b0;
        #1;
        chk_fire("mrst", 1'b0, 1'b0, 1'b0);
        chk("mrst.ready", 32'(dispatch_ready), 32'd1);
        chk("mrst.perf_dispatched", perf_dispatched, 32'd0);
        chk("mrst.perf_stall_rs", perf_stall_rs, 32'd0);
        chk("mrst.perf_stall_rob", perf_stall_rob, 32'd0);
        reset = 1'b1;
        sbq.delete();
        drv(2'd0, 7'd9, 7'd10, 7'd14, 7'd33, 4'd13, 1'b1, 1'b1, 1'b1);
        #1;
        chk_fire("mrst_empty", 1'b0, 1'b0, 1'b0);
        push();
        tick();
        idle();
        #1;
        chk_fire("post_rst_busy_clear", 1'b1, 1'b1, 1'b1);
        tick();
        chk("post_rst.perf_dispatched", perf_dispatched, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
